// File: rtl/div_if.sv
// ---------------------------------------------------------------
// div_if: start/ready/done handshake and operand/result bus for restoring_div16x8. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface div_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/restoring_div16x8.sv
// ---------------------------------------------------------------
// restoring_div16x8: 16/8 unsigned radix-2 restoring divider, one quotient bit per clock. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module restoring_div16x8 (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] q_reg;
  logic [8:0]  p_reg;
  logic [7:0]  d_reg;
  logic [3:0]  cnt;
  logic [15:0] quotient_r;
  logic [7:0]  remainder_r;
  logic        dbz_r;
  logic        done_r;

  logic        ready_w;
  logic        accept;
  logic        last_iter;
  logic [8:0]  p_shift;
  logic [9:0]  diff;
  logic        borrow;
  logic [15:0] q_next;
  logic [8:0]  p_next;

  assign ready_w   = (state != RUN);
  assign accept    = bus.start && ready_w;
  assign last_iter = (state == RUN) && (cnt == 4'd15);

  // Extra top bit of the subtraction is the borrow: set means the trial went negative.
  always_comb begin
    p_shift = {p_reg[7:0], q_reg[15]};
    diff    = {1'b0, p_shift} - {2'b00, d_reg};
    borrow  = diff[9];
    q_next  = {q_reg[14:0], ~borrow};
    p_next  = borrow ? p_shift : diff[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = RUN;
      RUN:        if (cnt == 4'd15) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= 16'h0000;
      p_reg       <= 9'h000;
      d_reg       <= 8'h00;
      cnt         <= 4'd0;
      quotient_r  <= 16'h0000;
      remainder_r <= 8'h00;
      dbz_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        q_reg <= bus.dividend;
        d_reg <= bus.divisor;
        p_reg <= 9'h000;
        cnt   <= 4'd0;
        dbz_r <= 1'b0;
      end else if (state == RUN) begin
        q_reg <= q_next;
        p_reg <= p_next;
        cnt   <= cnt + 4'd1;
        if (last_iter) begin
          done_r <= 1'b1;
          // A zero divisor still runs all iterations so latency never varies.
          if (d_reg == 8'h00) begin
            quotient_r  <= 16'hFFFF;
            remainder_r <= 8'h00;
            dbz_r       <= 1'b1;
          end else begin
            quotient_r  <= q_next;
            remainder_r <= p_next[7:0];
          end
        end
      end
    end
  end

  assign bus.ready       = ready_w;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

`default_nettype wire
